// File: rtl/game_sound_sequencer.sv
// Turns one-cycle game event pulses into timed tone sequences for the tone generator.
// Define SOUND_PREEMPT_EN to let a higher-priority event abort the melody in progress.
module game_sound_sequencer #(
    parameter int NOTE_CYCLES = 2500000,
    parameter int GAP_CYCLES  = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       winPulse,
    input  logic       losePulse,
    input  logic       scoredPulse,
    input  logic       collisionPulse,
    input  logic       mute,
    output logic       sound_enable,
    output logic [3:0] tone_index,
    output logic       busy,
    output logic       sound_done,
    output logic [3:0] pending
);

    localparam int MAX_CYCLES = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] NOTE_LAST = CW'(NOTE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [1:0]    event_sel;
    logic [1:0]    note_ptr;
    logic [1:0]    selected;
    logic [3:0]    event_pulses;
    logic [3:0]    clear_mask;
    logic          preempt;

    // Event index doubles as priority: 3 = lose (highest) down to 0 = collision.
    function automatic logic [1:0] top_event(input logic [3:0] p);
        if (p[3])      return 2'd3;
        else if (p[2]) return 2'd2;
        else if (p[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    function automatic logic [3:0] note_tone(input logic [1:0] ev, input logic [1:0] ptr);
        case (ev)
            2'd3: begin
                case (ptr)
                    2'd0:    return 4'd8;
                    2'd1:    return 4'd5;
                    2'd2:    return 4'd3;
                    default: return 4'd1;
                endcase
            end
            2'd2: begin
                case (ptr)
                    2'd0:    return 4'd1;
                    2'd1:    return 4'd3;
                    2'd2:    return 4'd5;
                    default: return 4'd8;
                endcase
            end
            2'd1:    return (ptr == 2'd0) ? 4'd5 : 4'd8;
            default: return 4'd10;
        endcase
    endfunction

    function automatic logic [1:0] last_note(input logic [1:0] ev);
        case (ev)
            2'd3, 2'd2: return 2'd3;
            2'd1:       return 2'd1;
            default:    return 2'd0;
        endcase
    endfunction

    assign event_pulses = {losePulse, winPulse, scoredPulse, collisionPulse};
    assign selected     = top_event(pending);

    always_comb begin
        clear_mask = 4'b0000;
        if (state == LOAD) clear_mask[selected] = 1'b1;
    end

`ifdef SOUND_PREEMPT_EN
    logic [3:0] higher;

    always_comb begin
        case (event_sel)
            2'd0:    higher = 4'b1110;
            2'd1:    higher = 4'b1100;
            2'd2:    higher = 4'b1000;
            default: higher = 4'b0000;
        endcase
    end

    assign preempt = ((state == PLAY) || (state == GAP)) && (|(pending & higher));
`else
    assign preempt = 1'b0;
`endif

    // Outputs are computed alongside the next state so they are all registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            event_sel    <= 2'd0;
            note_ptr     <= 2'd0;
            pending      <= 4'b0000;
            sound_enable <= 1'b0;
            tone_index   <= 4'd0;
            busy         <= 1'b0;
            sound_done   <= 1'b0;
        end else begin
            // A pulse landing in the LOAD cycle survives the clear, so that melody replays.
            pending    <= (pending & ~clear_mask) | event_pulses;
            sound_done <= 1'b0;
            case (state)
                IDLE: begin
                    sound_enable <= 1'b0;
                    tone_index   <= 4'd0;
                    busy         <= |pending;
                    if (|pending) state <= LOAD;
                end
                LOAD: begin
                    event_sel    <= selected;
                    note_ptr     <= 2'd0;
                    count        <= '0;
                    sound_enable <= !mute;
                    tone_index   <= note_tone(selected, 2'd0);
                    busy         <= 1'b1;
                    state        <= PLAY;
                end
                PLAY: begin
                    if (preempt) begin
                        state        <= LOAD;
                        count        <= '0;
                        sound_enable <= 1'b0;
                        tone_index   <= 4'd0;
                    end else if (count == NOTE_LAST) begin
                        state        <= GAP;
                        count        <= '0;
                        sound_enable <= 1'b0;
                        tone_index   <= 4'd0;
                    end else begin
                        count        <= count + CW'(1);
                        sound_enable <= !mute;
                    end
                end
                GAP: begin
                    if (preempt) begin
                        state        <= LOAD;
                        count        <= '0;
                        sound_enable <= 1'b0;
                        tone_index   <= 4'd0;
                    end else if (count == GAP_LAST) begin
                        count <= '0;
                        if (note_ptr == last_note(event_sel)) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            sound_done <= 1'b1;
                        end else begin
                            note_ptr     <= note_ptr + 2'd1;
                            state        <= PLAY;
                            sound_enable <= !mute;
                            tone_index   <= note_tone(event_sel, note_ptr + 2'd1);
                        end
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_sound_sequencer.sv
// Scoreboard bench for game_sound_sequencer: a melody-level reference model predicts each
// cycle's outputs, note onsets and completions; a negedge monitor pops and compares them.
module tb_game_sound_sequencer;

    localparam int NOTE  = 4;
    localparam int GAP   = 2;
    localparam int PERIOD = NOTE + GAP;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       winPulse = 1'b0;
    logic       losePulse = 1'b0;
    logic       scoredPulse = 1'b0;
    logic       collisionPulse = 1'b0;
    logic       mute = 1'b0;
    logic       sound_enable;
    logic [3:0] tone_index;
    logic       busy;
    logic       sound_done;
    logic [3:0] pending;

    game_sound_sequencer #(
        .NOTE_CYCLES(NOTE),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .winPulse      (winPulse),
        .losePulse     (losePulse),
        .scoredPulse   (scoredPulse),
        .collisionPulse(collisionPulse),
        .mute          (mute),
        .sound_enable  (sound_enable),
        .tone_index    (tone_index),
        .busy          (busy),
        .sound_done    (sound_done),
        .pending       (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       busy;
        logic [3:0] pend;
        logic       se;
    } status_t;

    typedef struct {
        int         cycle;
        logic [3:0] tone;
    } note_t;

    status_t status_q[$];
    note_t   note_q[$];
    int      done_q[$];

    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    logic running = 1'b0;

    // Reference model: pending set, phase (0 idle, 1 load, 2 melody) and melody start cycle.
    logic [3:0] m_pend;
    int         m_phase;
    int         m_ev;
    int         m_start;
    logic       m_prev_mute;
    logic       m_done;
    logic [3:0] m_prev_tone;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int melody_len(input int ev);
        case (ev)
            3, 2:    return 4;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [3:0] tone_of(input int ev, input int n);
        int lose_t[4] = '{8, 5, 3, 1};
        int win_t[4]  = '{1, 3, 5, 8};
        int score_t[2] = '{5, 8};
        case (ev)
            3:       return 4'(lose_t[n]);
            2:       return 4'(win_t[n]);
            1:       return 4'(score_t[n]);
            default: return 4'd10;
        endcase
    endfunction

    function automatic int top_of(input logic [3:0] p);
        for (int i = 3; i > 0; i--) if (p[i]) return i;
        return 0;
    endfunction

    task automatic modelReset();
        m_pend      = 4'b0000;
        m_phase     = 0;
        m_ev        = 0;
        m_start     = 0;
        m_prev_mute = 1'b0;
        m_done      = 1'b0;
        m_prev_tone = 4'd0;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    endtask

    task automatic reportFail(input string name, input int actual, input int expected);
        checks++;
        $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    endtask

    // One clock cycle of stimulus: drive inputs, publish this cycle's expectations, advance model.
    task automatic applyStimulus(input logic [3:0] p, input logic m, input logic r);
        int         off;
        logic [3:0] etone;
        logic       ese;
        logic [3:0] clr;
        logic       nd;
        logic       hit;
        @(posedge clk);
        #1;
        if (r && !reset) begin
            reset = 1'b1;
            #1;
            checkOutput("async_reset_outputs",
                        int'({sound_enable, tone_index, busy, sound_done, pending}), 0);
        end
        reset = r;
        {losePulse, winPulse, scoredPulse, collisionPulse} = r ? 4'b0000 : p;
        mute = m;
        if (r) modelReset();

        etone = 4'd0;
        ese   = 1'b0;
        if (m_phase == 2) begin
            off = cyc - m_start;
            if ((off % PERIOD) < NOTE) begin
                etone = tone_of(m_ev, off / PERIOD);
                ese   = !m_prev_mute;
            end
        end
        status_q.push_back('{busy: (m_phase != 0), pend: m_pend, se: ese});
        if (etone != 4'd0 && m_prev_tone == 4'd0) note_q.push_back('{cycle: cyc, tone: etone});
        if (m_done) done_q.push_back(cyc);
        m_prev_tone = etone;

        if (!r) begin
            clr = 4'b0000;
            nd  = 1'b0;
            case (m_phase)
                0: if (m_pend != 4'b0000) m_phase = 1;
                1: begin
                    m_ev       = top_of(m_pend);
                    clr[m_ev]  = 1'b1;
                    m_start    = cyc + 1;
                    m_phase    = 2;
                end
                default: begin
                    off = cyc - m_start;
                    hit = 1'b0;
`ifdef SOUND_PREEMPT_EN
                    hit = (int'(m_pend) >> (m_ev + 1)) != 0;
`endif
                    if (hit) m_phase = 1;
                    else if (off == melody_len(m_ev) * PERIOD - 1) begin
                        m_phase = 0;
                        nd      = 1'b1;
                    end
                end
            endcase
            m_pend      = (m_pend & ~clr) | p;
            m_prev_mute = m;
            m_done      = nd;
        end
    endtask

    task automatic idleCycles(input int n, input logic m);
        for (int i = 0; i < n; i++) applyStimulus(4'b0000, m, 1'b0);
    endtask

    // Monitor: every cycle presents status; note onsets and sound_done pop their own queues.
    logic [3:0] mon_prev_tone = 4'd0;
    always @(negedge clk) begin
        if (running) begin
            status_t s;
            note_t   n;
            int      d;
            if (status_q.size() == 0) reportFail("status_underflow", 1, 0);
            else begin
                s = status_q.pop_front();
                checkOutput("busy", int'(busy), int'(s.busy));
                checkOutput("pending", int'(pending), int'(s.pend));
                checkOutput("sound_enable", int'(sound_enable), int'(s.se));
            end
            if (tone_index != 4'd0 && mon_prev_tone == 4'd0) begin
                if (note_q.size() == 0) reportFail("unexpected_note", int'(tone_index), 0);
                else begin
                    n = note_q.pop_front();
                    checkOutput("note_start_cycle", cyc, n.cycle);
                    checkOutput("note_tone", int'(tone_index), int'(n.tone));
                end
            end
            if (sound_done) begin
                if (done_q.size() == 0) reportFail("unexpected_done", 1, 0);
                else begin
                    d = done_q.pop_front();
                    checkOutput("done_cycle", cyc, d);
                end
            end
            mon_prev_tone = tone_index;
        end
    end

    initial begin
        logic [3:0] p;
        logic       m;
        modelReset();
        running = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 1'b0, 1'b1);
        idleCycles(9, 1'b0);

        applyStimulus(4'b0100, 1'b0, 1'b0);
        idleCycles(30, 1'b0);

        applyStimulus(4'b0011, 1'b0, 1'b0);
        idleCycles(30, 1'b0);

        applyStimulus(4'b0001, 1'b0, 1'b0);
        idleCycles(3, 1'b0);
        applyStimulus(4'b1000, 1'b0, 1'b0);
        idleCycles(45, 1'b0);

        idleCycles(3, 1'b1);
        applyStimulus(4'b0100, 1'b1, 1'b0);
        idleCycles(30, 1'b1);
        idleCycles(2, 1'b0);

        applyStimulus(4'b1000, 1'b0, 1'b0);
        idleCycles(2, 1'b0);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        idleCycles(3, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        idleCycles(20, 1'b0);

        for (int i = 0; i < 3; i++) applyStimulus(4'b0010, 1'b0, 1'b0);
        idleCycles(20, 1'b0);
        idleCycles(4, 1'b0);
        applyStimulus(4'b0010, 1'b0, 1'b0);
        idleCycles(40, 1'b0);

        m = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 4; b++) p[b] = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 49) == 0) m = !m;
            applyStimulus(p, m, ($urandom_range(0, 499) == 0));
        end
        idleCycles(60, 1'b0);

        @(negedge clk);
        #1;
        running = 1'b0;
        checkOutput("notes_left", note_q.size(), 0);
        checkOutput("dones_left", done_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
